hex_scan_display: RTL
=====================

HEX_SCAN_DISPLAY -- requirements
Module: hex_scan_display

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning the number of input channels (>=2).
REQ-002 SHALL have parameter CH_W, default 8, meaning bits per channel (multiple of 4, 4..32).
REQ-003 SHALL have parameter DIV, default 50_000_000, meaning clock cycles per auto-scan dwell (>=2).
REQ-004 SHALL have parameter LZ_BLANK, default 0, meaning leading-zero digit suppression when 1.
REQ-005 SHALL have port clock, input, 1 bit: sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port data_in, input, NUM_CH*CH_W bits: channel k at bits [k*CH_W +: CH_W].
REQ-008 SHALL have port auto, input, 1 bit: 1 = auto-scan, 0 = manual select.
REQ-009 SHALL have port sel, input, $clog2(NUM_CH) bits: manual channel index.
REQ-010 SHALL have port hold, input, 1 bit: freezes scan position and displayed value.
REQ-011 SHALL have port blank, input, 1 bit: forces all segments off.
REQ-012 SHALL have port seg_out, output, 7*(CH_W/4) bits: active-low segments, digit 0 (LS nibble) at [6:0], bit order g..a.
REQ-013 SHALL have port ch_idx, output, $clog2(NUM_CH) bits: index of the displayed channel.
REQ-014 SHALL have port tick, output, 1 bit: one-cycle pulse on each auto advance.

Function
REQ-015 SHALL keep a registered index cur (drives ch_idx) and a prescaler counting 0..DIV-1.
REQ-016 SHALL, when auto=0 and hold=0, load cur from sel each cycle, with sel>=NUM_CH loading 0; prescaler held at 0.
REQ-017 SHALL, when auto=1 and hold=0, increment the prescaler each cycle; when it equals DIV-1, wrap it to 0 and advance cur (NUM_CH-1 wraps to 0).
REQ-018 SHALL register tick high in exactly the cycle cur takes its advanced value, and low otherwise; manual changes never pulse tick.
REQ-019 SHALL, when hold=1, freeze cur, prescaler and the snapshot register; hold takes priority over auto and sel.
REQ-020 SHALL restart the prescaler at 0 on the first cycle of auto=1 after auto=0.
REQ-021 SHALL register snapshot <= channel word selected by the next value of cur; seg_out SHALL therefore reflect data_in one cycle after a change, aligned with ch_idx.
REQ-022 SHALL decode each nibble: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-023 SHALL, with LZ_BLANK=1, drive 1111111 on every zero nibble above the most significant non-zero nibble; digit 0 SHALL always be shown.
REQ-024 SHALL drive all seg_out bits to 1 while blank=1; counters and snapshot SHALL continue unaffected.
REQ-025 SHALL drive seg_out combinationally from snapshot, blank and LZ_BLANK only (no data_in path).

Reset
REQ-026 SHALL, on reset=1 at a clock edge, set cur=0, prescaler=0, snapshot=0 and tick=0, overriding hold, auto and in-progress dwell.
REQ-027 SHALL therefore show all digits "0" after reset (LZ_BLANK=1: digit 0 "0", others blank), unless blank=1.

Structure
REQ-028 SHALL place the 16-entry segment table, the SEG_BLANK constant (7'h7F) and the nibble/segment widths in shared package hex_pkg.
REQ-029 SHALL instantiate combinational sub-module hex_seg_decode (4-bit nibble -> 7-bit segments) CH_W/4 times.

Verification (NUM_CH=4, CH_W=8, DIV=4 unless stated)
REQ-030 SHALL cover: reset -> ch_idx=0, tick=0, seg_out={1000000,1000000}.
REQ-031 SHALL cover: channels 0x12/0x34/0xAB/0xF0, auto=1 -> ch_idx 0,1,2,3,0 every 4 cycles, tick once per step; ch_idx=2 gives seg_out={0001000,0000011}.
REQ-032 SHALL cover: hold=1 for 10 cycles at prescaler=2 -> ch_idx and seg_out unchanged, no tick; after release, advance on 2nd cycle.
REQ-033 SHALL cover: NUM_CH=3, auto=0, sel=3 -> ch_idx=0 next cycle; sel=2 -> ch_idx=2, tick stays 0.
REQ-034 SHALL cover: LZ_BLANK=1, data 0x05 -> {1111111,0010010}; data 0x00 -> {1111111,1000000}; blank=1 -> all ones.
REQ-035 SHALL cover: reset asserted with ch_idx=3 and prescaler=3 -> next cycle ch_idx=0, no tick, next advance 4 cycles after release.

Source files
------------

// File: rtl/hex_pkg.sv
// Shared constants for the hex scan display: nibble/segment widths and glyph table.
// Latency: n/a (constants only).
// Backpressure: n/a.
package hex_pkg;

  localparam int NIB_W = 4;
  localparam int SEG_W = 7;

  // All segments off (active-low encoding).
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Active-low glyphs, bit order g..a (bit 6 = g, bit 0 = a), indexed by nibble.
  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

endpackage

// File: rtl/hex_seg_decode.sv
// Single hex nibble to active-low seven-segment glyph.
// Latency: purely combinational.
// Backpressure: none.
module hex_seg_decode
  import hex_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  output logic [SEG_W-1:0] seg
);

  // Table lookup of the glyph for this nibble.
  always_comb begin
    seg = SEG_TABLE[nib];
  end

endmodule

// File: rtl/hex_scan_display.sv
// Scans NUM_CH input words (auto dwell or manual select) onto a multi-digit hex display.
// Latency: ch_idx/seg_out follow a selection or data change one clock later.
// Backpressure: none; hold freezes scan position and the displayed snapshot.
module hex_scan_display
  import hex_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CH_W     = 8,
  parameter int DIV      = 50_000_000,
  parameter int LZ_BLANK = 0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_CH*CH_W-1:0]        data_in,
  input  logic                          auto,
  input  logic [$clog2(NUM_CH)-1:0]     sel,
  input  logic                          hold,
  input  logic                          blank,
  output logic [SEG_W*(CH_W/NIB_W)-1:0] seg_out,
  output logic [$clog2(NUM_CH)-1:0]     ch_idx,
  output logic                          tick
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int PW    = $clog2(DIV);
  localparam int NDIG  = CH_W / NIB_W;

  logic [IDX_W-1:0] cur_q, cur_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CH_W-1:0]  snap_q, snap_d;
  logic             tick_q, tick_d;
  logic             auto_q, auto_d;

  logic [PW-1:0]    presc_base;
  logic [CH_W-1:0]  word_sel;

  // Next-state: hold freezes everything; auto counts dwell, manual tracks sel.
  always_comb begin
    cur_d      = cur_q;
    presc_d    = presc_q;
    snap_d     = snap_q;
    tick_d     = 1'b0;
    auto_d     = auto;
    presc_base = '0;
    word_sel   = '0;
    if (!hold) begin
      if (auto) begin
        // A fresh entry into auto mode always starts a full dwell.
        presc_base = auto_q ? presc_q : '0;
        if (presc_base == PW'(DIV - 1)) begin
          presc_d = '0;
          tick_d  = 1'b1;
          cur_d   = (cur_q == IDX_W'(NUM_CH - 1)) ? '0 : cur_q + 1'b1;
        end else begin
          presc_d = presc_base + 1'b1;
        end
      end else begin
        presc_d = '0;
        cur_d   = (int'(sel) >= NUM_CH) ? '0 : sel;
      end
      // Snapshot follows the channel that cur is about to show.
      for (int k = 0; k < NUM_CH; k++) begin
        if (cur_d == IDX_W'(k)) begin
          word_sel = data_in[k*CH_W +: CH_W];
        end
      end
      snap_d = word_sel;
    end
  end

  // State register with synchronous reset overriding hold/auto.
  always_ff @(posedge clock) begin
    if (reset) begin
      cur_q   <= '0;
      presc_q <= '0;
      snap_q  <= '0;
      tick_q  <= 1'b0;
      auto_q  <= 1'b0;
    end else begin
      cur_q   <= cur_d;
      presc_q <= presc_d;
      snap_q  <= snap_d;
      tick_q  <= tick_d;
      auto_q  <= auto_d;
    end
  end

  assign ch_idx = cur_q;
  assign tick   = tick_q;

  logic [SEG_W-1:0] dig_seg [NDIG];

  genvar g;
  generate
    for (g = 0; g < NDIG; g++) begin : g_dig
      hex_seg_decode u_dec (
        .nib (snap_q[g*NIB_W +: NIB_W]),
        .seg (dig_seg[g])
      );
    end
  endgenerate

  logic nz_seen;

  // Output mux: blanking, then leading-zero suppression scanning from the top digit.
  always_comb begin
    seg_out = '0;
    nz_seen = 1'b0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      nz_seen = nz_seen | (snap_q[i*NIB_W +: NIB_W] != '0);
      if (blank) begin
        seg_out[i*SEG_W +: SEG_W] = SEG_BLANK;
      end else if ((LZ_BLANK != 0) && (i != 0) && !nz_seen) begin
        seg_out[i*SEG_W +: SEG_W] = SEG_BLANK;
      end else begin
        seg_out[i*SEG_W +: SEG_W] = dig_seg[i];
      end
    end
  end

endmodule
